// File: rtl/lc3b_types.sv
// Shared LC-3b types: default cache geometry, geometry aliases
// and the cache controller state encoding.
package lc3b_types;

   localparam int CACHE_IDX_BITS = 3;
   localparam int CACHE_OFF_BITS = 4;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef logic [CACHE_IDX_BITS-1:0] lc3b_c_index;
   typedef logic [CACHE_OFF_BITS-1:0] lc3b_c_offset;
   typedef logic [15-CACHE_IDX_BITS-CACHE_OFF_BITS:0] lc3b_c_tag;

   typedef enum logic [1:0] {
      s_compare,
      s_writeback,
      s_fill
   } lc3b_cache_state;

endpackage

// File: rtl/cache_array.sv
// Per-set storage array: combinational read, synchronous write,
// optional synchronous clear to zero.
// Ports: clk, rst_n, we_i, idx_i (set), wdata_i, rdata_o.
module cache_array #(
   parameter int WIDTH      = 1,
   parameter int DEPTH_BITS = 3,
   parameter bit RESETTABLE = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic [DEPTH_BITS-1:0] idx_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o
);

   logic [WIDTH-1:0] mem_q [2**DEPTH_BITS];

   always_ff @(posedge clk) begin
      if (RESETTABLE && !rst_n) begin
         for (int i = 0; i < 2**DEPTH_BITS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/lc3b_cache_2way.sv
// 2-way set-associative write-back write-allocate L1 cache, LRU.
// Ports: mem_* CPU word port, pmem_* line-wide memory port.
module lc3b_cache_2way
   import lc3b_types::*;
#(
   parameter int IDX_BITS = CACHE_IDX_BITS,
   parameter int OFF_BITS = CACHE_OFF_BITS,
   parameter int ADDR_W   = 16,
   localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS,
   localparam int LINE_W   = 8 * (2**OFF_BITS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_byte_enable,
   input  logic [15:0]       mem_wdata,
   output logic [15:0]       mem_rdata,
   output logic              mem_resp,
   output logic [ADDR_W-1:0] pmem_address,
   input  logic [LINE_W-1:0] pmem_rdata,
   output logic [LINE_W-1:0] pmem_wdata,
   output logic              pmem_read,
   output logic              pmem_write,
   input  logic              pmem_resp
);

   lc3b_cache_state state_q;
   logic                victim_q;
   logic [TAG_BITS-1:0] mtag_q;
   logic [IDX_BITS-1:0] midx_q;

   logic [TAG_BITS-1:0]   tag;
   logic [IDX_BITS-1:0]   idx;
   logic [IDX_BITS-1:0]   aidx;
   logic [OFF_BITS-2:0]   word;
   logic [LINE_W-1:0]     data_rd [2];
   logic [TAG_BITS-1:0]   tag_rd  [2];
   logic [1:0]            valid_rd;
   logic [1:0]            dirty_rd;
   logic [1:0]            hit;
   logic [1:0]            data_we;
   logic [1:0]            meta_we;
   logic [LINE_W-1:0]     data_wd;
   logic [LINE_W-1:0]     merged;
   logic                  dirty_wd;
   logic                  lru_rd;
   logic                  req;
   logic                  hit_any;
   logic                  hit_way;
   logic                  victim;
   logic                  cmp_hit;
   logic                  fill_done;
   int                    rbase;
   logic                  unused_addr0;

   assign tag  = mem_address[ADDR_W-1 -: TAG_BITS];
   assign idx  = mem_address[OFF_BITS +: IDX_BITS];
   assign word = mem_address[OFF_BITS-1:1];
   assign unused_addr0 = mem_address[0];

   // Outside COMPARE the arrays follow the latched miss set.
   assign aidx = (state_q == s_compare) ? idx : midx_q;

   assign req     = mem_read | mem_write;
   assign hit_any = |hit;
   assign hit_way = hit[1];
   assign victim  = !valid_rd[0] ? 1'b0 :
                    !valid_rd[1] ? 1'b1 : lru_rd;

   assign cmp_hit   = rst_n && (state_q == s_compare) && req && hit_any;
   assign fill_done = rst_n && (state_q == s_fill) && pmem_resp;

   always_comb begin
      rbase  = 16 * int'(word);
      merged = data_rd[hit_way];
      if (mem_byte_enable[0]) merged[rbase +: 8]     = mem_wdata[7:0];
      if (mem_byte_enable[1]) merged[rbase + 8 +: 8] = mem_wdata[15:8];
   end

   assign data_wd  = (state_q == s_compare) ? merged : pmem_rdata;
   // Write hits set dirty; fills clear it.
   assign dirty_wd = (state_q == s_compare);

   for (genvar w = 0; w < 2; w++) begin : g_way
      assign data_we[w] = (cmp_hit && mem_write && hit[w]) ||
                          (fill_done && victim_q == 1'(w));
      assign meta_we[w] = fill_done && victim_q == 1'(w);
      assign hit[w] = valid_rd[w] && (tag_rd[w] == tag);

      cache_array #(.WIDTH(LINE_W), .DEPTH_BITS(IDX_BITS)) u_data (
         .clk(clk), .rst_n(rst_n), .we_i(data_we[w]), .idx_i(aidx),
         .wdata_i(data_wd), .rdata_o(data_rd[w])
      );
      cache_array #(.WIDTH(TAG_BITS), .DEPTH_BITS(IDX_BITS)) u_tag (
         .clk(clk), .rst_n(rst_n), .we_i(meta_we[w]), .idx_i(aidx),
         .wdata_i(mtag_q), .rdata_o(tag_rd[w])
      );
      cache_array #(.WIDTH(1), .DEPTH_BITS(IDX_BITS), .RESETTABLE(1'b1)) u_valid (
         .clk(clk), .rst_n(rst_n), .we_i(meta_we[w]), .idx_i(aidx),
         .wdata_i(1'b1), .rdata_o(valid_rd[w])
      );
      cache_array #(.WIDTH(1), .DEPTH_BITS(IDX_BITS), .RESETTABLE(1'b1)) u_dirty (
         .clk(clk), .rst_n(rst_n), .we_i(data_we[w]), .idx_i(aidx),
         .wdata_i(dirty_wd), .rdata_o(dirty_rd[w])
      );
   end

   // LRU points at the way not used by the latest hit.
   cache_array #(.WIDTH(1), .DEPTH_BITS(IDX_BITS), .RESETTABLE(1'b1)) u_lru (
      .clk(clk), .rst_n(rst_n), .we_i(cmp_hit), .idx_i(aidx),
      .wdata_i(~hit_way), .rdata_o(lru_rd)
   );

   // Victim and miss address are latched so a dropped or changed
   // request cannot disturb an in-flight line transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= s_compare;
         victim_q <= 1'b0;
         mtag_q   <= '0;
         midx_q   <= '0;
      end else begin
         unique case (state_q)
            s_compare: begin
               if (req && !hit_any) begin
                  victim_q <= victim;
                  mtag_q   <= tag;
                  midx_q   <= idx;
                  state_q  <= (valid_rd[victim] && dirty_rd[victim]) ?
                              s_writeback : s_fill;
               end
            end
            s_writeback: if (pmem_resp) state_q <= s_fill;
            s_fill:      if (pmem_resp) state_q <= s_compare;
            default:     state_q <= s_compare;
         endcase
      end
   end

   assign mem_resp   = cmp_hit;
   assign mem_rdata  = data_rd[hit_way][rbase +: 16];
   assign pmem_read  = (state_q == s_fill);
   assign pmem_write = (state_q == s_writeback);
   assign pmem_wdata = pmem_write ? data_rd[victim_q] : '0;

   always_comb begin
      pmem_address = '0;
      unique case (state_q)
         s_writeback: pmem_address = {tag_rd[victim_q], midx_q, {OFF_BITS{1'b0}}};
         s_fill:      pmem_address = {mtag_q, midx_q, {OFF_BITS{1'b0}}};
         default:     pmem_address = '0;
      endcase
   end

endmodule

// File: doc/lc3b_cache_2way.md
Name: lc3b_cache_2way

Overview:
Parametrised 2-way set-associative, write-back, write-allocate L1 cache between the LC-3b datapath memory port and the line-wide physical memory port. It generalises the fixed cache geometry (8 sets, 16-byte lines, 9-bit tag) to configurable set count and line size. It adds associativity with per-set LRU replacement and dirty-line writeback.

Parameters:
IDX_BITS, 3, set index width; sets = 2**IDX_BITS (legal 1..8)
OFF_BITS, 4, byte offset width; line = 2**OFF_BITS bytes (legal 2..6)
ADDR_W, 16, address width; TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS (derived localparam)
LINE_W, 8*2**OFF_BITS, line width in bits (derived localparam, 128 at default)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
mem_address  in  ADDR_W  CPU byte address
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_byte_enable  in  2  lc3b_mem_wmask; 11 = word, 01 = low byte, 10 = high byte
mem_wdata  in  16  CPU write data
mem_rdata  out  16  selected word of hit line
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  ADDR_W  line-aligned physical address; low OFF_BITS are zero
pmem_rdata  in  LINE_W  fill data
pmem_wdata  out  LINE_W  victim line data
pmem_read  out  1  line fill request, held until pmem_resp
pmem_write  out  1  writeback request, held until pmem_resp
pmem_resp  in  1  physical memory completion pulse

Behaviour:
- Reset: FSM enters COMPARE. All valid, dirty and LRU bits clear. mem_resp, pmem_read and pmem_write are 0. Data and tag arrays are not reset.
- Reset mid-miss: next edge returns to COMPARE with pmem_read and pmem_write deasserted. Dirty contents are lost.
- Address split: tag = addr[ADDR_W-1 -: TAG_BITS], idx = addr[OFF_BITS +: IDX_BITS], word = addr[OFF_BITS-1:1]. addr[0] is ignored.
- Array reads are combinational. Array writes are synchronous.
- COMPARE, request active (mem_read|mem_write):
  - Hit is valid[w] && tag[w]==tag for either way. Both ways hitting cannot occur.
  - On a hit, mem_resp=1 combinationally in the same cycle. mem_rdata = word of the hit way.
  - On the hit edge, LRU[idx] is set to the other way.
  - Write hit: on the same edge, merge the bytes per mem_byte_enable into that word and set dirty.
- Miss victim selection: way0 if invalid, else way1 if invalid, else LRU[idx].
- Miss transitions: if the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, idx, 0}; pmem_wdata = victim line.
  - On pmem_resp, go to FILL.
- FILL:
  - pmem_read=1; pmem_address = {tag, idx, 0}.
  - On pmem_resp, write pmem_rdata into the victim way, set tag, set valid, clear dirty, and go to COMPARE.
  - The request then hits the following cycle.
- Latencies:
  - Clean miss: mem_resp one cycle after the FILL pmem_resp.
  - Dirty miss: an additional full writeback transaction before the fill.
- mem_read and mem_write both high is treated as a write.
- Request dropped mid-miss: the current pmem transaction completes and the line is installed; no mem_resp.
- No request in COMPARE: all outputs idle and no state change.
- mem_resp is never asserted outside COMPARE.

Decomposition:
- lc3b_types package:
  - Add localparams CACHE_IDX_BITS=3 and CACHE_OFF_BITS=4.
  - Add typedef lc3b_cache_state {s_compare, s_writeback, s_fill}.
  - Existing lc3b_c_index, lc3b_c_offset and lc3b_c_tag remain as default-geometry aliases.
- Sub-module cache_array #(WIDTH, DEPTH_BITS):
  - Synchronous write-enabled, async-read, resettable-to-zero option.
  - Instanced per way for data, tag, valid and dirty, plus once for LRU.
- Control FSM and datapath muxing stay in lc3b_cache_2way.

Test Plan:
- Cold read 0x1234 (defaults):
  - pmem_read with pmem_address 0x1230.
  - Return line with word2 = 0xBEEF → mem_rdata 0xBEEF with mem_resp one cycle after pmem_resp.
  - No pmem_write.
- Hit after fill: read 0x1230 → mem_resp same cycle, no pmem activity.
- Byte write 0x1235 (byte_enable 10, wdata 0xAA00) on a hit:
  - Next read 0x1234 returns 0xAAEF.
  - Dirty bit is set.
- Conflict on idx 3:
  - Sequence: fill 0x0030, 0x1030, read 0x0030, then read 0x2030.
  - 0x1030 is evicted (LRU).
  - Clean victim → no pmem_write; pmem_read to 0x2030.
- Dirty eviction:
  - Sequence: write 0x0030, touch 0x1030, then read 0x2030.
  - pmem_write to 0x0030 with the modified line first, then pmem_read to 0x2030.
- Reset in FILL:
  - rst_n=0 for one cycle → pmem_read=0 next cycle.
  - Subsequent read to the same address misses again.
  - Repeat with IDX_BITS=2, OFF_BITS=3: read 0x00F6 → pmem_address 0x00F0.
